// File: rtl/sent_pkg.sv
// Shared constants, FSM state encodings and the CRC4 lookup table for the SENT receiver.
package sent_pkg;

  localparam logic [7:0] SYNC_TICKS    = 8'd56;
  localparam logic [7:0] NIB_MIN_TICKS = 8'd12;
  localparam logic [7:0] NIB_MAX_TICKS = 8'd27;
  localparam logic [7:0] SAT_TICKS     = 8'd255;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_STATUS = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;
  localparam logic [1:0] ST_CRC    = 2'd3;

  function automatic logic [3:0] crc4_table(input logic [3:0] idx);
    case (idx)
      4'd0:  crc4_table = 4'd0;
      4'd1:  crc4_table = 4'd13;
      4'd2:  crc4_table = 4'd7;
      4'd3:  crc4_table = 4'd10;
      4'd4:  crc4_table = 4'd14;
      4'd5:  crc4_table = 4'd3;
      4'd6:  crc4_table = 4'd9;
      4'd7:  crc4_table = 4'd4;
      4'd8:  crc4_table = 4'd1;
      4'd9:  crc4_table = 4'd12;
      4'd10: crc4_table = 4'd6;
      4'd11: crc4_table = 4'd11;
      4'd12: crc4_table = 4'd15;
      4'd13: crc4_table = 4'd2;
      4'd14: crc4_table = 4'd8;
      4'd15: crc4_table = 4'd5;
    endcase
  endfunction

endpackage

// File: rtl/sent_crc4_nibble.sv
// One nibble-serial step of the SENT CRC4; augment applies the trailing zero-nibble step.
module sent_crc4_nibble
  import sent_pkg::*;
(
  input  logic [3:0] crc,
  input  logic [3:0] nibble,
  input  logic       augment,
  output logic [3:0] crc_next
);

  always_comb begin
    crc_next = crc4_table(crc);
    if (!augment) crc_next = crc_next ^ nibble;
  end

endmodule

// File: rtl/sent_rx_frame.sv
// SENT fast-channel receiver: measures fall-to-fall intervals in ticks, decodes
// sync/status/data/CRC nibbles and flags the frame as valid, CRC-bad or malformed.
module sent_rx_frame
  import sent_pkg::*;
#(
  parameter int         CLK_PER_TICK = 300,
  parameter int         DATA_NIBBLES = 6,
  parameter int         SYNC_TOL     = 1,
  parameter logic [3:0] CRC_SEED     = 4'b0101
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sent_in,
  output logic                      frame_valid,
  output logic                      crc_err,
  output logic                      frame_err,
  output logic [3:0]                status,
  output logic [4*DATA_NIBBLES-1:0] data,
  output logic [3:0]                crc_rx
);

  localparam int              PW         = $clog2(CLK_PER_TICK);
  localparam logic [PW-1:0]   PRESC_HALF = PW'(CLK_PER_TICK / 2);
  localparam logic [PW-1:0]   PRESC_FULL = PW'(CLK_PER_TICK - 1);
  localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
  localparam logic [7:0]      SYNC_LO    = 8'(int'(SYNC_TICKS) - SYNC_TOL);
  localparam logic [7:0]      SYNC_HI    = 8'(int'(SYNC_TICKS) + SYNC_TOL);
  localparam logic [2:0]      LAST_IDX   = 3'(DATA_NIBBLES - 1);

  logic                      sync1, sync2, prev, fall;
  logic [PW-1:0]             presc;
  logic [7:0]                ticks, ticks_now;
  logic                      is_sync, is_nib;
  logic [3:0]                nib_val;
  logic [1:0]                state;
  logic [2:0]                idx;
  logic [3:0]                crc_q, crc_step, status_sh, crc_sh;
  logic [4*DATA_NIBBLES-1:0] data_sh;
  logic                      done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= sent_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fall = prev & ~sync2;

  // The half-tick preload makes the count at the next fall round to the nearest tick;
  // ticks_now includes the increment landing on the sampling edge itself.
  always_comb begin
    ticks_now = ticks;
    if (presc == PRESC_ONE && ticks != SAT_TICKS) ticks_now = ticks + 8'd1;
    is_sync = (ticks_now >= SYNC_LO) && (ticks_now <= SYNC_HI);
    is_nib  = (ticks_now >= NIB_MIN_TICKS) && (ticks_now <= NIB_MAX_TICKS);
    nib_val = 4'(ticks_now - NIB_MIN_TICKS);
  end

  always_ff @(posedge clk) begin
    if (!reset || fall) begin
      presc <= PRESC_HALF;
      ticks <= 8'd0;
    end else begin
      ticks <= ticks_now;
      presc <= (presc == '0) ? PRESC_FULL : presc - PRESC_ONE;
    end
  end

  sent_crc4_nibble u_crc (
    .crc      (crc_q),
    .nibble   (nib_val),
    .augment  (state == ST_CRC),
    .crc_next (crc_step)
  );

  // A sync seen mid-frame is reused as the start of the next frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_HUNT;
      idx       <= 3'd0;
      crc_q     <= 4'd0;
      status_sh <= 4'd0;
      crc_sh    <= 4'd0;
      data_sh   <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        if (state == ST_HUNT) begin
          if (is_sync) state <= ST_STATUS;
        end else if (is_sync) begin
          frame_err <= 1'b1;
          state     <= ST_STATUS;
        end else if (!is_nib) begin
          frame_err <= 1'b1;
          state     <= ST_HUNT;
        end else begin
          case (state)
            ST_STATUS: begin
              status_sh <= nib_val;
              idx       <= 3'd0;
              crc_q     <= CRC_SEED;
              state     <= ST_DATA;
            end
            ST_DATA: begin
              data_sh[4*(DATA_NIBBLES-1-int'(idx)) +: 4] <= nib_val;
              crc_q <= crc_step;
              idx   <= idx + 3'd1;
              if (idx == LAST_IDX) state <= ST_CRC;
            end
            default: begin
              crc_sh <= nib_val;
              crc_q  <= crc_step;
              done   <= 1'b1;
              state  <= ST_HUNT;
            end
          endcase
        end
      end else if (state != ST_HUNT && ticks == SAT_TICKS) begin
        frame_err <= 1'b1;
        state     <= ST_HUNT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_valid <= 1'b0;
      crc_err     <= 1'b0;
      status      <= 4'd0;
      data        <= '0;
      crc_rx      <= 4'd0;
    end else begin
      frame_valid <= 1'b0;
      crc_err     <= 1'b0;
      if (done) begin
        status      <= status_sh;
        data        <= data_sh;
        crc_rx      <= crc_sh;
        frame_valid <= (crc_q == crc_sh);
        crc_err     <= (crc_q != crc_sh);
      end
    end
  end

endmodule

// File: tb/tb_sent_rx_frame.sv
// Scoreboard bench for sent_rx_frame: directed SENT frames with hand-computed CRCs.
module tb_sent_rx_frame;

  localparam int CPT = 4;
  localparam int NN  = 6;

  localparam logic [2:0] K_VALID  = 3'b001;
  localparam logic [2:0] K_CRCERR = 3'b010;
  localparam logic [2:0] K_FERR   = 3'b100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sent_in = 1'b1;
  logic        frame_valid, crc_err, frame_err;
  logic [3:0]  status, crc_rx;
  logic [23:0] data;

  typedef struct packed {
    logic [2:0]  kind;
    logic [3:0]  st;
    logic [23:0] d;
    logic [3:0]  c;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [3:0]  last_st = 4'd0;
  logic [3:0]  last_c = 4'd0;
  logic [23:0] last_d = 24'd0;

  always #5 clk = ~clk;

  sent_rx_frame #(
    .CLK_PER_TICK (CPT),
    .DATA_NIBBLES (NN),
    .SYNC_TOL     (1),
    .CRC_SEED     (4'b0101)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sent_in     (sent_in),
    .frame_valid (frame_valid),
    .crc_err     (crc_err),
    .frame_err   (frame_err),
    .status      (status),
    .data        (data),
    .crc_rx      (crc_rx)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, got, want);
    end
  endtask

  // A frame_err leaves the outputs holding the last completed frame.
  task automatic expectFrame(input logic [2:0] kind, input logic [3:0] st, input logic [23:0] d,
                             input logic [3:0] c);
    exp_t e;
    if (kind != K_FERR) begin
      last_st = st;
      last_d  = d;
      last_c  = c;
    end
    e.kind = kind;
    e.st   = last_st;
    e.d    = last_d;
    e.c    = last_c;
    sb.push_back(e);
  endtask

  task automatic send_interval(input int clks);
    sent_in = 1'b0;
    repeat (2) @(negedge clk);
    sent_in = 1'b1;
    repeat (clks - 2) @(negedge clk);
  endtask

  task automatic send_ticks(input int t, input int jit);
    send_interval(t * CPT + jit);
  endtask

  task automatic sendPartial(input logic [3:0] st, input logic [23:0] d, input int count);
    logic [3:0] n;
    send_ticks(56, 0);
    send_ticks(12 + int'(st), 0);
    for (int i = 0; i < count; i++) begin
      n = d[4*(NN-1-i) +: 4];
      send_ticks(12 + int'(n), 0);
    end
  endtask

  // Sends sync..CRC; the fall closing the CRC nibble comes from whatever is sent next.
  task automatic applyStimulus(input int sync_t, input logic [3:0] st, input logic [23:0] d,
                               input logic [3:0] c, input int jit);
    logic [3:0] n;
    send_ticks(sync_t, 0);
    send_ticks(12 + int'(st), jit);
    for (int i = 0; i < NN; i++) begin
      n = d[4*(NN-1-i) +: 4];
      send_ticks(12 + int'(n), (i % 2 == 0) ? -jit : jit);
    end
    send_ticks(12 + int'(c), -jit);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset && (frame_valid || crc_err || frame_err)) begin
        exp_t e;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_pulse: got kind=%b expected none",
                   {frame_err, crc_err, frame_valid});
        end else begin
          e = sb.pop_front();
          checkOutput("pulse_kind", {29'd0, frame_err, crc_err, frame_valid}, {29'd0, e.kind});
          checkOutput("status", {28'd0, status}, {28'd0, e.st});
          checkOutput("data", {8'd0, data}, {8'd0, e.d});
          checkOutput("crc_rx", {28'd0, crc_rx}, {28'd0, e.c});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b0;
    sent_in = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    checkOutput("rst_crc_err", {31'd0, crc_err}, 32'd0);
    checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("rst_status", {28'd0, status}, 32'd0);
    checkOutput("rst_data", {8'd0, data}, 32'd0);
    checkOutput("rst_crc_rx", {28'd0, crc_rx}, 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] nominal frames and CRC error");
    expectFrame(K_VALID, 4'h0, 24'h000000, 4'h5);
    applyStimulus(56, 4'h0, 24'h000000, 4'h5, 0);
    expectFrame(K_VALID, 4'h3, 24'h123456, 4'h2);
    applyStimulus(56, 4'h3, 24'h123456, 4'h2, 0);
    expectFrame(K_CRCERR, 4'h3, 24'h123456, 4'h3);
    applyStimulus(56, 4'h3, 24'h123456, 4'h3, 0);

    $display("[TB] sync tolerance");
    expectFrame(K_VALID, 4'hA, 24'h000000, 4'h5);
    applyStimulus(55, 4'hA, 24'h000000, 4'h5, 0);
    expectFrame(K_VALID, 4'h3, 24'h123456, 4'h2);
    applyStimulus(57, 4'h3, 24'h123456, 4'h2, 0);
    applyStimulus(54, 4'h0, 24'h000000, 4'h5, 0);

    $display("[TB] jitter and pause");
    expectFrame(K_VALID, 4'hC, 24'hFFFFFF, 4'hA);
    applyStimulus(56, 4'hC, 24'hFFFFFF, 4'hA, CPT / 2 - 1);
    send_ticks(40, 0);
    expectFrame(K_VALID, 4'h3, 24'h123456, 4'h2);
    applyStimulus(56, 4'h3, 24'h123456, 4'h2, -(CPT / 2 - 1));
    send_ticks(40, 0);

    $display("[TB] illegal interval in DATA");
    expectFrame(K_FERR, 4'h0, 24'h0, 4'h0);
    sendPartial(4'h5, 24'h123456, 2);
    send_ticks(30, 0);
    expectFrame(K_VALID, 4'h0, 24'h000000, 4'h5);
    applyStimulus(56, 4'h0, 24'h000000, 4'h5, 0);

    $display("[TB] sync inside DATA");
    expectFrame(K_FERR, 4'h0, 24'h0, 4'h0);
    sendPartial(4'h7, 24'hFFFFFF, 3);
    expectFrame(K_VALID, 4'h3, 24'h123456, 4'h2);
    applyStimulus(56, 4'h3, 24'h123456, 4'h2, 0);

    $display("[TB] line stuck high in DATA");
    expectFrame(K_FERR, 4'h0, 24'h0, 4'h0);
    sendPartial(4'h1, 24'h123456, 2);
    send_interval(270 * CPT);
    expectFrame(K_VALID, 4'hA, 24'hFFFFFF, 4'hA);
    applyStimulus(56, 4'hA, 24'hFFFFFF, 4'hA, 0);

    $display("[TB] reset during DATA");
    sendPartial(4'h2, 24'h000000, 2);
    sent_in = 1'b0;
    repeat (2) @(negedge clk);
    sent_in = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_frame_valid", {31'd0, frame_valid}, 32'd0);
    checkOutput("midrst_crc_err", {31'd0, crc_err}, 32'd0);
    checkOutput("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("midrst_status", {28'd0, status}, 32'd0);
    checkOutput("midrst_data", {8'd0, data}, 32'd0);
    checkOutput("midrst_crc_rx", {28'd0, crc_rx}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    expectFrame(K_VALID, 4'h3, 24'h123456, 4'h2);
    applyStimulus(56, 4'h3, 24'h123456, 4'h2, 0);
    send_ticks(40, 0);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    checkOutput("sb_drain", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sent_rx_frame.md
Name: sent_rx_frame

Overview:
- SENT (SAE J2716) fast-channel receiver. It is the receive end that checks the CRC the transmit side appends.
- Measures falling-edge-to-falling-edge intervals on the SENT line, finds the 56-tick sync pulse, and decodes the status nibble, DATA_NIBBLES data nibbles and the CRC nibble.
- Recomputes the CRC4 over the data nibbles and presents the frame with valid and error flags to downstream sensor logic.

Parameters:
- CLK_PER_TICK, 300: clk cycles per SENT tick (3 us at 100 MHz); minimum 4.
- DATA_NIBBLES, 6: data nibbles per frame, 1..6.
- SYNC_TOL, 1: accepted sync window is 56±SYNC_TOL ticks.
- CRC_SEED, 4'b0101: CRC4 seed.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- sent_in  in  1  raw SENT line, asynchronous to clk
- frame_valid  out  1  one-cycle pulse: frame decoded and CRC matched
- crc_err  out  1  one-cycle pulse: frame decoded but CRC mismatched
- frame_err  out  1  one-cycle pulse: illegal interval inside a frame
- status  out  4  status/comm nibble of the last decoded frame
- data  out  4*DATA_NIBBLES  data nibbles, first received in the MS nibble
- crc_rx  out  4  received CRC nibble

Behaviour:
- Reset (reset==0 at a clk edge):
  - all outputs 0; state HUNT; synchronizer flops 1.
  - Reset mid-frame discards the partial frame.
- Input path:
  - 2-flop synchronizer, then an edge register.
  - fall = prev & ~cur. fall is 3 clk after sent_in falls.
- Tick measurement:
  - On every fall, the prescaler is loaded with CLK_PER_TICK/2 and the tick count is cleared.
  - Prescaler decrements each clk. On reaching 0 it reloads CLK_PER_TICK-1 and increments the tick count.
  - Sampled tick count = round(clk interval / CLK_PER_TICK).
  - Tick count saturates at 255.
- Interval classification, evaluated on fall:
  - SYNC: |ticks-56| <= SYNC_TOL.
  - NIB: 12 <= ticks <= 27, nibble value = ticks-12.
  - OTHER: anything else.
- States: HUNT, STATUS, DATA, CRC.
  - HUNT: SYNC -> STATUS. NIB/OTHER are ignored (pause pulse, noise).
  - STATUS: NIB -> store status, go to DATA, load nibble index 0, load the CRC seed.
  - DATA: each NIB stores nibble[idx] and steps the CRC. After DATA_NIBBLES nibbles -> CRC.
  - CRC: NIB -> complete frame (see below) -> HUNT.
  - Any SYNC in STATUS/DATA/CRC -> frame_err pulse, then restart at STATUS (the sync is reused).
  - Any OTHER in STATUS/DATA/CRC -> frame_err pulse -> HUNT.
  - Saturation (255 ticks) in a non-HUNT state -> frame_err pulse -> HUNT, without waiting for an edge.
- CRC (J2716 recommended method):
  - Nibble-serial: c = nib ^ T[c], with T = {0,13,7,10,14,3,9,4,1,12,6,11,15,2,8,5}.
  - After the last data nibble apply one augment step c = T[c].
  - The status nibble is excluded from the CRC.
- Frame completion:
  - On the fall ending the CRC nibble, one clk later: status/data/crc_rx update together.
  - Then exactly one of frame_valid or crc_err pulses for 1 clk.
  - Outputs hold until the next completed frame.
  - A frame_err does not alter status/data/crc_rx.
- Back-to-back frames: the fall ending the CRC nibble also starts the next interval measurement, so no edge is lost.

Decomposition:
- Package sent_pkg:
  - SYNC_TICKS=56, NIB_MIN_TICKS=12, NIB_MAX_TICKS=27, SAT_TICKS=255
  - CRC4 table function
  - state enum {HUNT,STATUS,DATA,CRC}
- Sub-module sent_crc4_nibble: combinational next-CRC from (crc, nibble, augment).
- The synchronizer, prescaler and FSM stay in sent_rx_frame.

Test Plan:
- All-zero frame (CLK_PER_TICK=4): sync 56, status 12, six nibbles of 12 ticks, CRC nibble of 17 ticks -> frame_valid=1, data=0x000000, status=0, crc_rx=5.
- Data 0x123456, status 0x3, CRC nibble 2 (14 ticks) -> frame_valid, data=0x123456, status=3, crc_rx=2. Repeat with CRC nibble 3 -> crc_err=1, frame_valid=0, crc_rx=3.
- Tolerance:
  - sync of 55 ticks and 57 ticks each accepted;
  - sync of 54 ticks ignored (no pulse);
  - nibble intervals driven at ±CLK_PER_TICK/2-1 clk jitter decode correctly.
- Back-to-back frames with no pause, then a 40-tick pause between frames -> two frame_valid pulses each, pause ignored.
- Mid-frame faults:
  - 30-tick interval in DATA -> frame_err, then the next valid frame decodes;
  - sync arriving in DATA -> frame_err plus immediate decode of the following frame;
  - line held high >255 ticks in DATA -> frame_err.
- Reset asserted during the DATA state -> outputs 0 next clk; the first full frame after release decodes.
